// File: rtl/pong_pkg.sv
// pong_pkg: shared types, serve constants and velocity helpers for the pong controller. Rev 1.0
// PONG_BALL_SPEEDUP_EN: when defined, each paddle hit grows |vx| by one up to MAX_VX.
`default_nettype none

package pong_pkg;

    typedef logic [15:0]        coord_t;
    typedef logic signed [7:0]  vel_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_MOVE       = 3'd2,
        ST_COLLIDE    = 3'd3,
        ST_PADDLE     = 3'd4,
        ST_SCORE      = 3'd5,
        ST_GAME_OVER  = 3'd6
    } state_e;

    localparam vel_t SERVE_VX = 8'sd2;
    localparam vel_t SERVE_VY = 8'sd1;
    localparam vel_t MAX_VX   = 8'sd6;

    function automatic vel_t reflect_vx(input vel_t vx);
`ifdef PONG_BALL_SPEEDUP_EN
        vel_t mag;
        mag = vx[7] ? -vx : vx;
        if (mag < MAX_VX) begin
            mag = mag + 8'sd1;
        end
        return vx[7] ? mag : -mag;
`else
        return -vx;
`endif
    endfunction

    // Scores stick at 4'hF so a large WIN_SCORE can never wrap the counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'hF) ? 4'hF : s + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pong_game_controller_if.sv
// pong_game_controller_if: request/ack handshake to the AI paddle-update unit. Rev 1.0
`default_nettype none

interface pong_game_controller_if;
    import pong_pkg::*;

    logic        paddle_req;
    logic        paddle_ack;
    logic [31:0] paddle_pos_in;

    modport master (output paddle_req, input paddle_ack, input paddle_pos_in);
    modport slave  (input paddle_req, output paddle_ack, output paddle_pos_in);

endinterface

`default_nettype wire

// File: rtl/pong_collision_check.sv
// pong_collision_check: combinational wall, paddle and miss detection on the moved ball. Rev 1.0
`default_nettype none

module pong_collision_check
    import pong_pkg::*;
#(
    parameter int SCREEN_W           = 640,
    parameter int SCREEN_H           = 480,
    parameter int HALF_PADDLE_HEIGHT = 50
) (
    input  coord_t ball_x,
    input  coord_t ball_y,
    input  coord_t left_paddle_y,
    input  coord_t right_paddle_y,
    output logic   wall_hit,
    output logic   left_hit,
    output logic   right_hit,
    output logic   miss_l,
    output logic   miss_r
);

    localparam logic signed [15:0] C_BOTTOM     = 16'(SCREEN_H - 1);
    localparam logic signed [15:0] C_LEFT_ZONE  = 16'sd8;
    localparam logic signed [15:0] C_RIGHT_ZONE = 16'(SCREEN_W - 9);
    localparam logic signed [15:0] C_RIGHT_EDGE = 16'(SCREEN_W - 1);
    localparam logic signed [16:0] C_HALF       = 17'(HALF_PADDLE_HEIGHT);

    logic signed [15:0] w_x;
    logic signed [15:0] w_y;
    logic signed [16:0] w_dl;
    logic signed [16:0] w_dr;
    logic signed [16:0] w_adl;
    logic signed [16:0] w_adr;

    // Coordinates are treated as signed so a ball stepping past zero reads as off-screen.
    assign w_x   = signed'(ball_x);
    assign w_y   = signed'(ball_y);
    assign w_dl  = signed'({ball_y[15], ball_y}) - signed'({left_paddle_y[15], left_paddle_y});
    assign w_dr  = signed'({ball_y[15], ball_y}) - signed'({right_paddle_y[15], right_paddle_y});
    assign w_adl = w_dl[16] ? -w_dl : w_dl;
    assign w_adr = w_dr[16] ? -w_dr : w_dr;

    assign wall_hit  = (w_y <= 16'sd0) || (w_y >= C_BOTTOM);
    assign left_hit  = (w_x <= C_LEFT_ZONE) && (w_adl <= C_HALF);
    assign right_hit = (w_x >= C_RIGHT_ZONE) && (w_adr <= C_HALF);
    assign miss_l    = (w_x <= 16'sd0) && !left_hit;
    assign miss_r    = (w_x >= C_RIGHT_EDGE) && !right_hit;

endmodule

`default_nettype wire

// File: rtl/pong_game_controller.sv
// pong_game_controller: frame-driven pong ball/score FSM with AI paddle handshake. Rev 1.0
// PONG_BALL_SPEEDUP_EN (see pong_pkg) enables paddle-hit speedup of the ball.
`default_nettype none

module pong_game_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_W           = 640,
    parameter int SCREEN_H           = 480,
    parameter int HALF_PADDLE_HEIGHT = 50,
    parameter int WIN_SCORE          = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          start,
    input  logic [15:0]                   left_paddle_y,
    output logic [31:0]                   ball_pos,
    output logic [15:0]                   ball_vel,
    pong_game_controller_if.master        paddle_if,
    output logic [3:0]                    score_l,
    output logic [3:0]                    score_r,
    output logic [1:0]                    player_scored,
    output logic                          event_pulse,
    output logic                          game_over
);

    localparam coord_t C_CX    = 16'(SCREEN_W / 2);
    localparam coord_t C_CY    = 16'(SCREEN_H / 2);
    localparam coord_t C_Y_MIN = 16'd1;
    localparam coord_t C_Y_MAX = 16'(SCREEN_H - 2);

    state_e      state_q, state_d;
    coord_t      ball_x_q, ball_x_d;
    coord_t      ball_y_q, ball_y_d;
    vel_t        vx_q, vx_d;
    vel_t        vy_q, vy_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [1:0]  scorer_q, scorer_d;
    logic [1:0]  player_scored_q, player_scored_d;
    logic        event_pulse_q, event_pulse_d;

    logic        w_wall_hit, w_left_hit, w_right_hit, w_miss_l, w_miss_r;
    logic [3:0]  w_new_score;
    logic        w_unused_paddle_x;

    pong_collision_check #(
        .SCREEN_W           (SCREEN_W),
        .SCREEN_H           (SCREEN_H),
        .HALF_PADDLE_HEIGHT (HALF_PADDLE_HEIGHT)
    ) u_collision (
        .ball_x         (ball_x_q),
        .ball_y         (ball_y_q),
        .left_paddle_y  (left_paddle_y),
        .right_paddle_y (paddle_if.paddle_pos_in[15:0]),
        .wall_hit       (w_wall_hit),
        .left_hit       (w_left_hit),
        .right_hit      (w_right_hit),
        .miss_l         (w_miss_l),
        .miss_r         (w_miss_r)
    );

    assign w_unused_paddle_x = ^paddle_if.paddle_pos_in[31:16];
    assign w_new_score       = sat_inc(scorer_q[0] ? score_l_q : score_r_q);

    always_comb begin
        state_d         = state_q;
        ball_x_d        = ball_x_q;
        ball_y_d        = ball_y_q;
        vx_d            = vx_q;
        vy_d            = vy_q;
        score_l_d       = score_l_q;
        score_r_d       = score_r_q;
        scorer_d        = scorer_q;
        player_scored_d = 2'b00;
        event_pulse_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_d   = ST_WAIT_FRAME;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    ball_x_d  = C_CX;
                    ball_y_d  = C_CY;
                    vx_d      = SERVE_VX;
                    vy_d      = SERVE_VY;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                ball_x_d = ball_x_q + coord_t'({{8{vx_q[7]}}, vx_q});
                ball_y_d = ball_y_q + coord_t'({{8{vy_q[7]}}, vy_q});
                state_d  = ST_COLLIDE;
            end
            ST_COLLIDE: begin
                // Wall and paddle reflections are independent and may both apply.
                if (w_wall_hit) begin
                    vy_d     = -vy_q;
                    ball_y_d = (signed'(ball_y_q) <= 16'sd0) ? C_Y_MIN : C_Y_MAX;
                end
                if (w_left_hit || w_right_hit) begin
                    vx_d = reflect_vx(vx_q);
                end
                if (w_miss_l || w_miss_r) begin
                    state_d  = ST_SCORE;
                    scorer_d = w_miss_r ? 2'b01 : 2'b10;
                end else begin
                    state_d  = ST_PADDLE;
                end
            end
            ST_PADDLE: begin
                if (paddle_if.paddle_ack) begin
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_SCORE: begin
                if (scorer_q[0]) begin
                    score_l_d = w_new_score;
                end else begin
                    score_r_d = w_new_score;
                end
                player_scored_d = scorer_q;
                event_pulse_d   = 1'b1;
                ball_x_d        = C_CX;
                ball_y_d        = C_CY;
                vx_d            = -vx_q;
                state_d         = (w_new_score == 4'(WIN_SCORE)) ? ST_GAME_OVER : ST_WAIT_FRAME;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            ball_x_q        <= '0;
            ball_y_q        <= '0;
            vx_q            <= '0;
            vy_q            <= '0;
            score_l_q       <= '0;
            score_r_q       <= '0;
            scorer_q        <= '0;
            player_scored_q <= '0;
            event_pulse_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ball_x_q        <= ball_x_d;
            ball_y_q        <= ball_y_d;
            vx_q            <= vx_d;
            vy_q            <= vy_d;
            score_l_q       <= score_l_d;
            score_r_q       <= score_r_d;
            scorer_q        <= scorer_d;
            player_scored_q <= player_scored_d;
            event_pulse_q   <= event_pulse_d;
        end
    end

    // Request decoded straight from the state register so reset drops it immediately.
    assign paddle_if.paddle_req = (state_q == ST_PADDLE);
    assign game_over            = (state_q == ST_GAME_OVER);
    assign ball_pos             = {ball_x_q, ball_y_q};
    assign ball_vel             = {vx_q, vy_q};
    assign score_l              = score_l_q;
    assign score_r              = score_r_q;
    assign player_scored        = player_scored_q;
    assign event_pulse          = event_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: scoreboard bench driving full rallies through the pong controller. Rev 1.0
`default_nettype none

module tb_pong_game_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [15:0] left_paddle_y = 16'd0;
    logic [31:0] ball_pos;
    logic [15:0] ball_vel;
    logic [3:0]  score_l, score_r;
    logic [1:0]  player_scored;
    logic        event_pulse, game_over;

    pong_game_controller_if pif();

    pong_game_controller dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start         (start),
        .left_paddle_y (left_paddle_y),
        .ball_pos      (ball_pos),
        .ball_vel      (ball_vel),
        .paddle_if     (pif),
        .score_l       (score_l),
        .score_r       (score_r),
        .player_scored (player_scored),
        .event_pulse   (event_pulse),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_score;
        logic [31:0] pos;
        logic [15:0] vel;
        logic [1:0]  who;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        over;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   ack_en = 1'b1;

    // Reference ball/score state, written from the rules rather than the RTL structure.
    int m_x, m_y, m_vx, m_vy, m_sl, m_sr, left_hits;
    bit m_over;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_new();
        m_x = 320; m_y = 240; m_vx = 2; m_vy = 1;
        m_sl = 0; m_sr = 0; m_over = 1'b0; left_hits = 0;
    endtask

    task automatic model_frame(input int ly, input int ry, output bit sc, output bit rh, output bit wb);
        int x, y;
        bit wall, lh;
        exp_t e;
        x = m_x + m_vx;
        y = m_y + m_vy;
        wb   = (y == 479);
        wall = (y <= 0) || (y >= 479);
        lh   = (x <= 8) && (iabs(y - ly) <= 50);
        rh   = (x >= 631) && (iabs(y - ry) <= 50);
        if (wall) begin
            m_vy = -m_vy;
            y = (y < 1) ? 1 : 478;
        end
        if (lh || rh) m_vx = -m_vx;
        if (lh) left_hits++;
        m_x = x; m_y = y;
        sc = ((x <= 0) && !lh) || ((x >= 639) && !rh);
        e.is_score = sc;
        e.who = 2'b00;
        if (sc) begin
            if (x >= 639) begin
                m_sl = m_sl + 1; e.who = 2'b01;
            end else begin
                m_sr = m_sr + 1; e.who = 2'b10;
            end
            m_vx = -m_vx; m_x = 320; m_y = 240;
            m_over = (m_sl == 7) || (m_sr == 7);
        end
        e.pos  = {16'(m_x), 16'(m_y)};
        e.vel  = {8'(m_vx), 8'(m_vy)};
        e.sl   = 4'(m_sl);
        e.sr   = 4'(m_sr);
        e.over = m_over;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic begin_game();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        model_new();
    endtask

    // Right paddle tracks the ball once the left player has scored; left paddle tracks for one hit at 3 points.
    task automatic play_frame(output bit sc, output bit rh, output bit wb);
        int py, ly, ry;
        py = m_y + m_vy;
        ly = (m_sr == 3 && left_hits == 0) ? py : py + 200;
        ry = (m_sl >= 1) ? py : py + 200;
        left_paddle_y     = 16'(ly);
        pif.paddle_pos_in = {16'd632, 16'(ry)};
        model_frame(ly, ry, sc, rh, wb);
        tick();
    endtask

    initial begin
        pif.paddle_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (pif.paddle_req && ack_en) begin
                repeat (2) @(negedge clk);
                pif.paddle_ack = 1'b1;
                @(negedge clk);
                pif.paddle_ack = 1'b0;
            end
        end
    end

    bit   mon_prev_req = 1'b0;
    bit   mon_prev_ev  = 1'b0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (pif.paddle_req && !mon_prev_req) begin
                chk("sb_queue_nonempty_req", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("sb_expect_paddle", 64'(mon_e.is_score), 0);
                    chk("sb_paddle_pos", ball_pos, mon_e.pos);
                    chk("sb_paddle_vel", ball_vel, mon_e.vel);
                end
            end
            if (event_pulse) begin
                chk("event_pulse_width", 64'(mon_prev_ev), 0);
                chk("sb_queue_nonempty_ev", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("sb_expect_score", 64'(mon_e.is_score), 1);
                    chk("sb_player_scored", player_scored, mon_e.who);
                    chk("sb_score_l", score_l, mon_e.sl);
                    chk("sb_score_r", score_r, mon_e.sr);
                    chk("sb_score_pos", ball_pos, mon_e.pos);
                    chk("sb_score_vel", ball_vel, mon_e.vel);
                    chk("sb_game_over", game_over, mon_e.over);
                end
            end
            mon_prev_req = pif.paddle_req;
            mon_prev_ev  = event_pulse;
        end
    end

    initial begin
        bit sc, rh, wb;
        bit seen_sc = 1'b0, seen_rh = 1'b0, seen_wb = 1'b0;
        int frames = 0;
        pif.paddle_pos_in = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ball_pos", ball_pos, 0);
        chk("rst_ball_vel", ball_vel, 0);
        chk("rst_scores", {score_l, score_r}, 0);
        chk("rst_paddle_req", pif.paddle_req, 0);
        chk("rst_event", {event_pulse, player_scored, game_over}, 0);
        @(negedge clk) rst = 1'b1;

        tick();
        chk("idle_tick_dropped", ball_pos, 0);

        begin_game();
        while (!m_over && frames < 6000) begin
            if (frames == 1) ack_en = 1'b0;
            play_frame(sc, rh, wb);
            frames++;
            if (frames == 1) chk("first_move_pos", ball_pos, {16'd322, 16'd241});
            if (frames == 2) begin
                chk("paddle_req_held", pif.paddle_req, 1);
                @(posedge clk); #1 frame_tick = 1'b1;
                @(posedge clk); #1 frame_tick = 1'b0;
                repeat (2) @(posedge clk);
                #1 chk("tick_in_paddle_dropped", ball_pos, {16'd324, 16'd242});
                ack_en = 1'b1;
                repeat (6) @(posedge clk);
                #1 chk("paddle_req_released", pif.paddle_req, 0);
            end
            if (sc && !seen_sc) begin
                seen_sc = 1'b1;
                chk("first_score_l", score_l, 1);
                chk("first_score_recentre", ball_pos, {16'd320, 16'd240});
                chk("first_score_vel", ball_vel, {8'hFE, 8'h01});
            end
            if (rh && !seen_rh) begin
                seen_rh = 1'b1;
                chk("right_hit_vel", ball_vel, {8'hFE, 8'h01});
                chk("right_hit_pos", ball_pos, {16'd632, 16'd396});
                chk("right_hit_no_score", {score_l, score_r}, {4'd1, 4'd1});
            end
            if (wb && !seen_wb) begin
                seen_wb = 1'b1;
                chk("bottom_wall_pos", ball_pos, {16'd466, 16'd478});
                chk("bottom_wall_vel", ball_vel, {8'hFE, 8'hFF});
            end
        end

        chk("final_game_over", game_over, 1);
        chk("final_scores", {score_l, score_r}, {4'd1, 4'd7});
        repeat (3) tick();
        chk("over_hold_pos", ball_pos, {16'd320, 16'd240});
        chk("over_hold_vel", ball_vel, {8'(m_vx), 8'(m_vy)});
        chk("over_hold_scores", {score_l, score_r, game_over}, {4'd1, 4'd7, 1'b1});

        begin_game();
        #1;
        chk("restart_state", {game_over, score_l, score_r}, 0);
        chk("restart_ball", {ball_pos, ball_vel}, {16'd320, 16'd240, 8'h02, 8'h01});

        ack_en = 1'b0;
        play_frame(sc, rh, wb);
        chk("req_before_reset", pif.paddle_req, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", pif.paddle_req, 0);
        chk("async_rst_ball", {ball_pos, ball_vel}, 0);
        chk("async_rst_flags", {event_pulse, player_scored, game_over, score_l, score_r}, 0);
        @(negedge clk) rst = 1'b1;
        ack_en = 1'b1;

        begin_game();
        play_frame(sc, rh, wb);
        chk("post_reset_move", ball_pos, {16'd322, 16'd241});

        repeat (5) @(posedge clk);
        #1 chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pong_game_controller.md
PONG_GAME_CONTROLLER -- requirements
Module: pong_game_controller

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, playfield width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 480, playfield height in pixels.
REQ-003 SHALL have parameter HALF_PADDLE_HEIGHT, default 50, paddle half-height in pixels.
REQ-004 SHALL have parameter WIN_SCORE, default 7, points needed to end the game.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-008 SHALL have port start, input, 1, level; begins a game from IDLE or GAME_OVER.
REQ-009 SHALL have port left_paddle_y, input, 16, player paddle centre Y.
REQ-010 SHALL have port ball_pos, output, 32, {X[31:16], Y[15:0]}.
REQ-011 SHALL have port ball_vel, output, 16, {signed vx[15:8], signed vy[7:0]}.
REQ-012 SHALL have port paddle_req, output, 1, request to the AI paddle-update unit.
REQ-013 SHALL have port paddle_ack, input, 1, update complete; paddle_pos_in is valid.
REQ-014 SHALL have port paddle_pos_in, input, 32, {X, Y} of the AI (right) paddle.
REQ-015 SHALL have port score_l, output, 4, left player score.
REQ-016 SHALL have port score_r, output, 4, right player score.
REQ-017 SHALL have port player_scored, output, 2, 01 left / 10 right, valid with event_pulse.
REQ-018 SHALL have port event_pulse, output, 1, one-cycle pulse on each point scored.
REQ-019 SHALL have port game_over, output, 1, high while in GAME_OVER.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_FRAME, MOVE, COLLIDE, PADDLE, SCORE, GAME_OVER.
REQ-021 IDLE->WAIT_FRAME on start=1; the transition SHALL clear the scores, centre the ball at (SCREEN_W/2, SCREEN_H/2) and set the velocity to vx=+2, vy=+1.
REQ-022 WAIT_FRAME->MOVE on frame_tick; a frame_tick arriving in any other state SHALL be dropped (no queueing).
REQ-023 MOVE SHALL add sign-extended vx/vy to X/Y in 16-bit two's-complement arithmetic, then go to COLLIDE; the cycle is fixed at 1.
REQ-024 COLLIDE, Y <= 0 or Y >= SCREEN_H-1: SHALL negate vy and clamp Y into [1, SCREEN_H-2].
REQ-025 COLLIDE, X <= 8 with |Y-left_paddle_y| <= HALF_PADDLE_HEIGHT: SHALL negate vx (left hit); the right edge (X >= SCREEN_W-9) SHALL be checked against paddle_pos_in[15:0] the same way.
REQ-026 COLLIDE, X <= 0 or X >= SCREEN_W-1 without a hit: SHALL go to SCORE; otherwise SHALL go to PADDLE.
REQ-027 If a wall bounce and a paddle hit occur in the same COLLIDE cycle, both reflections SHALL be applied.
REQ-028 PADDLE SHALL assert paddle_req and hold it until the cycle where paddle_ack=1, then deassert it and go to WAIT_FRAME; no timeout.
REQ-029 SCORE SHALL increment the scorer's score, pulse event_pulse with player_scored for exactly 1 cycle, re-centre the ball, and negate vx (serve toward the loser).
REQ-030 SCORE SHALL go to GAME_OVER if the new score equals WIN_SCORE, otherwise to WAIT_FRAME.
REQ-031 GAME_OVER SHALL hold all outputs and go to IDLE->new game only on start=1; scores saturate at 4'hF regardless of WIN_SCORE.
REQ-032 paddle_ack outside PADDLE SHALL be ignored.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, ball_pos=0, ball_vel=0, scores=0, paddle_req=0, event_pulse=0, player_scored=0, game_over=0.
REQ-034 Reset asserted during PADDLE SHALL drop paddle_req immediately; the downstream unit must tolerate the abandoned request.

Configuration
REQ-035 With macro PONG_BALL_SPEEDUP_EN defined, each paddle hit SHALL increase |vx| by 1 up to 6, keeping the sign; without it, |vx| SHALL be constant at 2.

Structure
REQ-036 Package pong_pkg SHALL hold the state enum, the coord_t (16-bit) and vel_t (8-bit signed) typedefs, and the serve velocity constants.
REQ-037 Collision checks SHALL be in the combinational sub-module pong_collision_check (inputs ball, paddles, params; outputs wall_hit, left_hit, right_hit, miss_l, miss_r).

Verification
REQ-038 Reset, then start=1 and frame_tick -> ball_pos={322,241} after MOVE, and paddle_req=1 in PADDLE.
REQ-039 Ball Y=479, vy=+1, frame_tick -> vy=-1 and Y clamped to 478.
REQ-040 Ball X=638, vx=+2, paddle_pos_in Y=240, ball Y=260 -> vx=-2 and no score.
REQ-041 Same as REQ-040 but ball Y=400 -> score_l=1, event_pulse for 1 cycle, player_scored=01, ball re-centred, vx=-2.
REQ-042 score_r=6, left miss -> score_r=7, game_over=1; further frame_ticks change nothing until start.
REQ-043 rst=0 while paddle_req=1 and paddle_ack held low -> paddle_req=0 in the same cycle, state IDLE.
